// File: rtl/alu_pkg.sv
// Shared types and constants for the nibble-serial add/subtract unit.
package alu_pkg;

    localparam int unsigned ALU_NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/adder_4bits.sv
// 4-bit carry-lookahead adder slice.
module adder_4bits (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        s    = p ^ c[3:0];
        co   = c[4];
    end

endmodule

// File: rtl/nibble_serial_alu_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract: one shared 4-bit CLA slice, one nibble per cycle LSB first.
module nibble_serial_alu_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned NIBBLES = WIDTH / ALU_NIBBLE_W;
    localparam int unsigned IDX_W   = $clog2(NIBBLES);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_b_q, result_q, result_nxt;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q, cout_q, ovf_q, zero_q;
    logic [3:0]       nib_a, nib_b, slice_sum;
    logic             slice_co, accept, last;
    int unsigned      base;

    adder_4bits u_slice (
        .a  (nib_a),
        .b  (nib_b),
        .ci (carry_q),
        .s  (slice_sum),
        .co (slice_co)
    );

    // Flush blocks acceptance so an abort never races a new request.
    assign accept = start && !flush && (state_q != ST_RUN);
    assign last   = (idx_q == IDX_W'(NIBBLES - 1));

    always_comb begin
        base       = 32'(idx_q) * ALU_NIBBLE_W;
        nib_a      = op_a_q[base +: ALU_NIBBLE_W];
        nib_b      = op_b_q[base +: ALU_NIBBLE_W];
        result_nxt = result_q;
        result_nxt[base +: ALU_NIBBLE_W] = slice_sum;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_RUN;
            ST_RUN: begin
                if (flush)     state_d = ST_IDLE;
                else if (last) state_d = ST_DONE;
            end
            ST_DONE: state_d = accept ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_a_q  <= a;
                op_b_q  <= sub ? ~b : b;
                carry_q <= sub;
                idx_q   <= '0;
            end else if (state_q == ST_RUN && !flush) begin
                result_q <= result_nxt;
                carry_q  <= slice_co;
                idx_q    <= idx_q + 1'b1;
                if (last) begin
                    cout_q <= slice_co;
                    ovf_q  <= (op_a_q[WIDTH-1] == op_b_q[WIDTH-1])
                           && (slice_sum[3] != op_a_q[WIDTH-1]);
                    zero_q <= (result_nxt == '0);
                end
            end
        end
    end

    assign ready    = (state_q != ST_RUN);
    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Directed self-checking bench for nibble_serial_alu_ctrl (WIDTH=32).
module tb_nibble_serial_alu_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, sub, flush;
    logic [31:0] a, b, result;
    logic        ready, busy, done, cout, overflow, zero;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    nibble_serial_alu_ctrl #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .flush    (flush),
        .a        (a),
        .b        (b),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow),
        .zero     (zero)
    );

    // Raise start, then count edges until done (returns 99 on timeout).
    task automatic run_op(input logic [31:0] aa, input logic [31:0] bb, input logic s,
                          output int cyc);
        @(negedge clk);
        a = aa; b = bb; sub = s; start = 1'b1;
        cyc = 99;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (i == 1) start = 1'b0;
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sub = 1'b0; flush = 1'b0; a = '0; b = '0;
        #12;
        checks++;
        if ({ready, busy, done, cout, overflow, zero} !== 6'b100000 || result !== 32'h0) begin
            failures++;
            $display("FAIL reset: rdy/busy/done/cout/ovf/zero=%b result=%h required 100000 0",
                     {ready, busy, done, cout, overflow, zero}, result);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_add_wrap();
        int cyc;
        run_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, cyc);
        checks++;
        if (cyc !== 9) begin
            failures++; $display("FAIL wrap_latency: got %0d required 9", cyc);
        end
        checks++;
        if (result !== 32'h0 || {cout, overflow, zero} !== 3'b101) begin
            failures++;
            $display("FAIL wrap_result: got %h c/o/z=%b required 00000000 101", result,
                     {cout, overflow, zero});
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || ready !== 1'b1) begin
            failures++; $display("FAIL done_one_cycle: done=%b ready=%b required 0 1", done, ready);
        end
    endtask

    task automatic test_sub_overflow();
        int cyc;
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, cyc);
        checks++;
        if (cyc !== 9 || result !== 32'h7FFF_FFFF || {cout, overflow, zero} !== 3'b110) begin
            failures++;
            $display("FAIL sub_ovf: cyc=%0d result=%h c/o/z=%b required 9 7fffffff 110", cyc,
                     result, {cout, overflow, zero});
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, cyc);
        checks++;
        if (cyc !== 9 || result !== 32'h2345_6789 || cout !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first: cyc=%0d result=%h cout=%b required 9 23456789 0", cyc,
                     result, cout);
        end
        // Still inside the DONE cycle: present the next request now.
        a = 32'h5; b = 32'h7; sub = 1'b1; start = 1'b1;
        cyc = 99;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                start = 1'b0;
                checks++;
                if (busy !== 1'b1) begin
                    failures++; $display("FAIL b2b_accept: busy=%b required 1", busy);
                end
            end
            if (done) begin
                cyc = i;
                break;
            end
        end
        checks++;
        if (cyc !== 9 || result !== 32'hFFFF_FFFE || {cout, overflow, zero} !== 3'b000) begin
            failures++;
            $display("FAIL b2b_second: cyc=%0d result=%h c/o/z=%b required 9 fffffffe 000", cyc,
                     result, {cout, overflow, zero});
        end
    endtask

    task automatic test_ignored_start();
        int ndone = 0;
        int first = 0;
        logic [31:0] res = '0;
        @(negedge clk);
        a = 32'h0000_000F; b = 32'h0000_0001; sub = 1'b0; start = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (i == 1) start = 1'b0;
            if (i == 3) begin
                a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; sub = 1'b1; start = 1'b1;
            end
            if (i == 4) start = 1'b0;
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    first = i; res = result;
                end
            end
        end
        checks++;
        if (ndone !== 1 || first !== 9 || res !== 32'h0000_0010) begin
            failures++;
            $display("FAIL ignored_start: pulses=%0d at=%0d result=%h required 1 9 00000010",
                     ndone, first, res);
        end
    endtask

    task automatic test_flush();
        int ndone = 0;
        int cyc;
        @(negedge clk);
        a = 32'hAAAA_AAAA; b = 32'h1111_1111; sub = 1'b0; start = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            if (i == 1) start = 1'b0;
            if (i == 4) flush = 1'b1;
            if (done) ndone++;
        end
        flush = 1'b0;
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle: ready=%b busy=%b done=%b required 1 0 0", ready, busy, done);
        end
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            failures++; $display("FAIL flush_no_done: pulses=%0d required 0", ndone);
        end
        run_op(32'h0001_0000, 32'h0000_0001, 1'b1, cyc);
        checks++;
        if (cyc !== 9 || result !== 32'h0000_FFFF || {cout, overflow, zero} !== 3'b100) begin
            failures++;
            $display("FAIL flush_restart: cyc=%0d result=%h c/o/z=%b required 9 0000ffff 100",
                     cyc, result, {cout, overflow, zero});
        end
    endtask

    task automatic test_async_reset();
        int ndone = 0;
        @(negedge clk);
        a = 32'h7777_7777; b = 32'h1111_1111; sub = 1'b0; start = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            if (i == 1) start = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ready, busy, done, cout, overflow, zero} !== 6'b100000 || result !== 32'h0) begin
            failures++;
            $display("FAIL async_reset: rdy/busy/done/cout/ovf/zero=%b result=%h required 100000 0",
                     {ready, busy, done, cout, overflow, zero}, result);
        end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        checks++;
        if (ndone !== 0 || ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release: pulses=%0d ready=%b required 0 1", ndone, ready);
        end
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_sub_overflow();
        test_back_to_back();
        test_ignored_start();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
